// File: rtl/clf_pkg.sv
// Shared constants for the combination-lock front end and lock FSM.
package clf_pkg;

    localparam int unsigned SEL_W         = 2;
    localparam int unsigned N_SW_DEF      = 8;
    localparam int unsigned DB_CYCLES_DEF = 1_000_000;
    localparam int unsigned CNT_W_DEF     = 20;
    localparam int unsigned LOCKOUT_DEF   = 5_000_000;

    // Bits needed to hold values 0..val.
    function automatic int unsigned width_for(input int unsigned val);
        return (val < 2) ? 1 : $clog2(val + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser followed by a stable-level debounce counter.
module sw_debounce_bit
    import clf_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic db_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/sw_input_conditioner.sv
// Switch front end: per-bit debounce, rising-edge detect, any/code press pulses.
// Optional hold-off after each event is enabled by defining SW_LOCKOUT_EN.
module sw_input_conditioner
    import clf_pkg::*;
#(
    parameter int unsigned N_SW      = N_SW_DEF,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned LOCKOUT   = LOCKOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SW-1:0]  sw,
    input  logic [SEL_W-1:0] sel,
    output logic             codesw,
    output logic             anysw,
    output logic [N_SW-1:0]  sw_db
);

    if ((64'(1) << CNT_W) < 64'(DB_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DB_CYCLES");
    end
    if (N_SW < (1 << SEL_W)) begin : g_bad_n_sw
        $error("N_SW must cover every sel value");
    end
    if (LOCKOUT == 0) begin : g_bad_lockout
        $error("LOCKOUT must be non-zero");
    end

    logic [N_SW-1:0] db;
    logic [N_SW-1:0] sw_db_q;
    logic [N_SW-1:0] rise;
    logic            anysw_q, anysw_d;
    logic            codesw_q, codesw_d;
    logic            ev_en;

    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        sw_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .sw_i (sw[i]),
            .db_o (db[i])
        );
    end

    assign rise = db & ~sw_db_q;

`ifdef SW_LOCKOUT_EN
    localparam int unsigned LkW = width_for(LOCKOUT);

    logic [LkW-1:0] lock_cnt_q, lock_cnt_d;

    assign ev_en = (lock_cnt_q == '0);

    // Reload on every issued event; rises seen while non-zero are dropped.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (anysw_d) begin
            lock_cnt_d = LkW'(LOCKOUT);
        end else if (lock_cnt_q != '0) begin
            lock_cnt_d = lock_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    assign ev_en = 1'b1;
`endif

    always_comb begin
        anysw_d  = ev_en & (|rise);
        codesw_d = ev_en & rise[sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_db_q  <= '0;
            anysw_q  <= 1'b0;
            codesw_q <= 1'b0;
        end else begin
            sw_db_q  <= db;
            anysw_q  <= anysw_d;
            codesw_q <= codesw_d;
        end
    end

    assign sw_db  = db;
    assign anysw  = anysw_q;
    assign codesw = codesw_q;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner (DB_CYCLES=4, LOCKOUT=10, N_SW=8).
module tb_sw_input_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] sw  = 8'h00;
    logic [1:0] sel = 2'd0;
    logic       codesw, anysw;
    logic [7:0] sw_db;

    int checks = 0;
    int errors = 0;

    sw_input_conditioner #(
        .N_SW      (8),
        .DB_CYCLES (4),
        .CNT_W     (20),
        .LOCKOUT   (10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw),
        .sel    (sel),
        .codesw (codesw),
        .anysw  (anysw),
        .sw_db  (sw_db)
    );

    always #5 clk = ~clk;

    // Step n cycles, sampling 1 time unit after each rising edge; tallies pulses.
    task automatic run(input int n, output int na, output int nc, output int first_a,
                       output int last_a, output int orphan);
        na = 0; nc = 0; first_a = 0; last_a = 0; orphan = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (anysw === 1'b1) begin
                na++;
                if (first_a == 0) first_a = k;
                last_a = k;
            end
            if (codesw === 1'b1) nc++;
            if (codesw === 1'b1 && anysw !== 1'b1) orphan++;
        end
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        int na, nc, fa, la, orp;
        sw = 8'hFF;
        sel = 2'd0;
        #1 rst = 1'b1;
        settle(3);
        checks++; if (anysw !== 1'b0) begin errors++; $display("FAIL reset_anysw: got %b want 0", anysw); end
        checks++; if (codesw !== 1'b0) begin errors++; $display("FAIL reset_codesw: got %b want 0", codesw); end
        checks++; if (sw_db !== 8'h00) begin errors++; $display("FAIL reset_sw_db: got %h want 00", sw_db); end
        rst = 1'b0;
        run(10, na, nc, fa, la, orp);
        checks++; if (na != 1) begin errors++; $display("FAIL reset_release_count: got %0d want 1", na); end
        checks++; if (fa != 7) begin errors++; $display("FAIL reset_release_latency: got %0d want 7", fa); end
        checks++; if (nc != 1) begin errors++; $display("FAIL reset_release_code: got %0d want 1", nc); end
        checks++; if (sw_db !== 8'hFF) begin errors++; $display("FAIL reset_release_sw_db: got %h want ff", sw_db); end
        sw = 8'h00;
        run(20, na, nc, fa, la, orp);
        checks++; if (na != 0) begin errors++; $display("FAIL release_all_no_event: got %0d want 0", na); end
        checks++; if (sw_db !== 8'h00) begin errors++; $display("FAIL release_all_sw_db: got %h want 00", sw_db); end
    endtask

    task automatic test_clean_press;
        int na, nc, fa, la, orp;
        sel = 2'd2;
        sw = 8'h04;
        run(6, na, nc, fa, la, orp);
        checks++; if (na != 0) begin errors++; $display("FAIL clean_early: got %0d pulses want 0", na); end
        run(4, na, nc, fa, la, orp);
        checks++; if (na != 1 || fa != 1) begin errors++; $display("FAIL clean_any: got count %0d at %0d want 1 at 1", na, fa); end
        checks++; if (nc != 1) begin errors++; $display("FAIL clean_code: got %0d want 1", nc); end
        checks++; if (sw_db !== 8'h04) begin errors++; $display("FAIL clean_sw_db: got %h want 04", sw_db); end
        sw = 8'h00;
        settle(15);
    endtask

    task automatic test_bounce;
        int na, nc, fa, la, orp;
        int tot;
        tot = 0;
        sel = 2'd2;
        for (int t = 0; t < 10; t++) begin
            sw[1] = ~sw[1];
            run(2, na, nc, fa, la, orp);
            tot += na;
        end
        checks++; if (tot != 0) begin errors++; $display("FAIL bounce_during: got %0d want 0", tot); end
        sw[1] = 1'b1;
        run(12, na, nc, fa, la, orp);
        checks++; if (na != 1 || fa != 7) begin errors++; $display("FAIL bounce_final: got count %0d at %0d want 1 at 7", na, fa); end
        checks++; if (nc != 0) begin errors++; $display("FAIL bounce_code: got %0d want 0", nc); end
        sw = 8'h00;
        settle(15);
    endtask

    task automatic test_wrong_key;
        int na, nc, fa, la, orp;
        sel = 2'd0;
        sw = 8'h20;
        run(10, na, nc, fa, la, orp);
        checks++; if (na != 1 || fa != 7) begin errors++; $display("FAIL wrong_any: got count %0d at %0d want 1 at 7", na, fa); end
        checks++; if (nc != 0) begin errors++; $display("FAIL wrong_code: got %0d want 0", nc); end
        sw = 8'h00;
        settle(15);
        sw = 8'h21;
        run(10, na, nc, fa, la, orp);
        checks++; if (na != 1 || fa != 7) begin errors++; $display("FAIL dual_any: got count %0d at %0d want 1 at 7", na, fa); end
        checks++; if (nc != 1) begin errors++; $display("FAIL dual_code: got %0d want 1", nc); end
        checks++; if (orp != 0) begin errors++; $display("FAIL dual_orphan: got %0d want 0", orp); end
        sw = 8'h00;
        settle(15);
    endtask

    task automatic test_hold_release;
        int na, nc, fa, la, orp;
        sel = 2'd3;
        sw = 8'h08;
        run(50, na, nc, fa, la, orp);
        checks++; if (na != 1 || fa != 7) begin errors++; $display("FAIL hold_any: got count %0d at %0d want 1 at 7", na, fa); end
        checks++; if (nc != 1) begin errors++; $display("FAIL hold_code: got %0d want 1", nc); end
        checks++; if (sw_db !== 8'h08) begin errors++; $display("FAIL hold_sw_db: got %h want 08", sw_db); end
        sw = 8'h00;
        run(20, na, nc, fa, la, orp);
        checks++; if (na != 0) begin errors++; $display("FAIL release_event: got %0d want 0", na); end
        checks++; if (sw_db !== 8'h00) begin errors++; $display("FAIL release_sw_db: got %h want 00", sw_db); end
    endtask

    task automatic test_back_to_back;
        int na, nc, fa, la, orp;
        sel = 2'd1;
        sw = 8'h01;
        run(3, na, nc, fa, la, orp);
        sw = 8'h03;
        run(20, na, nc, fa, la, orp);
`ifdef SW_LOCKOUT_EN
        checks++; if (na != 1 || fa != 4) begin errors++; $display("FAIL lockout_any: got count %0d at %0d want 1 at 4", na, fa); end
        checks++; if (nc != 0) begin errors++; $display("FAIL lockout_code: got %0d want 0", nc); end
`else
        checks++; if (na != 2 || fa != 4 || la != 7) begin
            errors++; $display("FAIL b2b_any: got count %0d at %0d/%0d want 2 at 4/7", na, fa, la);
        end
        checks++; if (nc != 1) begin errors++; $display("FAIL b2b_code: got %0d want 1", nc); end
`endif
        checks++; if (sw_db !== 8'h03) begin errors++; $display("FAIL b2b_sw_db: got %h want 03", sw_db); end
        sw = 8'h00;
        settle(20);
        sw = 8'h02;
        run(10, na, nc, fa, la, orp);
        checks++; if (na != 1 || fa != 7) begin errors++; $display("FAIL repress_any: got count %0d at %0d want 1 at 7", na, fa); end
        checks++; if (nc != 1) begin errors++; $display("FAIL repress_code: got %0d want 1", nc); end
        sw = 8'h00;
        settle(15);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrong_key();
        test_hold_release();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
